// File: rtl/shift_issue_stage_pkg.sv
// rtl/shift_issue_stage_pkg.sv - shared constants and shift decode for the shift issue stage
package shift_issue_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] SRL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] NOP = 2'b11;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [1:0] alusel;
    logic       illegal;
  } shift_dec_t;

  // imm[10] is instruction bit 30, the SRL/SRA selector
  function automatic shift_dec_t decode_shift(input logic        is_shift,
                                              input logic        is_imm,
                                              input logic [2:0]  funct3,
                                              input logic [11:0] imm);
    shift_dec_t d;
    d.alusel  = NOP;
    d.illegal = 1'b0;
    if (is_shift) begin
      case (funct3)
        F3_SLL: begin
          d.alusel = SLL;
          if (!is_imm && imm[10]) d.illegal = 1'b1;
        end
        F3_SR:   d.alusel = imm[10] ? SRA : SRL;
        default: d.illegal = 1'b1;
      endcase
      if (is_imm && (((imm[11:5] != FUNCT7_ZERO) && (imm[11:5] != FUNCT7_ALT)) || imm[5]))
        d.illegal = 1'b1;
      if (d.illegal) d.alusel = NOP;
    end
    return d;
  endfunction

endpackage

// File: rtl/shift_issue_stage_fwd_select.sv
// rtl/shift_issue_stage_fwd_select.sv - operand forwarding select, EX/MEM over MEM/WB, x0 reads zero
module fwd_select
  import shift_issue_stage_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] addr,
  input  logic [XW-1:0] rf_data,
  input  logic          exm_wen,
  input  logic [AW-1:0] exm_rd,
  input  logic [XW-1:0] exm_data,
  input  logic          mwb_wen,
  input  logic [AW-1:0] mwb_rd,
  input  logic [XW-1:0] mwb_data,
  output logic [XW-1:0] data
);

  logic nonzero;
  logic exm_hit;
  logic mwb_hit;

  assign nonzero = (addr != '0);
  assign exm_hit = nonzero && exm_wen && (exm_rd == addr);
  assign mwb_hit = nonzero && mwb_wen && (mwb_rd == addr);

  always_comb begin
    data = '0;
    if (exm_hit)      data = exm_data;
    else if (mwb_hit) data = mwb_data;
    else if (nonzero) data = rf_data;
  end

endmodule

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - ID/EX register slice feeding the shifter with forwarded operands
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int XLEN   = shift_issue_stage_pkg::XLEN,
  parameter int REG_AW = shift_issue_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_is_shift,
  input  logic              in_is_imm,
  input  logic [2:0]        in_funct3,
  input  logic [11:0]       in_imm,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic              exm_wen,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_wen,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_a,
  output logic [4:0]        out_shamt,
  output logic [1:0]        out_alusel,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_illegal
);

  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              is_imm_q;

  logic [REG_AW-1:0] src1_addr;
  logic [REG_AW-1:0] src2_addr;
  logic [XLEN-1:0]   src1_rf;
  logic [XLEN-1:0]   src2_rf;
  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;
  logic              unused_fwd2_hi;
  shift_dec_t        dec;

  // While stalled the fallback is the held value, so a miss leaves the operand unchanged
  assign src1_addr = stall ? rs1_q : in_rs1_addr;
  assign src2_addr = stall ? rs2_q : in_rs2_addr;
  assign src1_rf   = stall ? out_a : in_rs1_data;
  assign src2_rf   = stall ? {{(XLEN-5){1'b0}}, out_shamt} : in_rs2_data;

  fwd_select #(.XW(XLEN), .AW(REG_AW)) u_fwd_rs1 (
    .addr     (src1_addr),
    .rf_data  (src1_rf),
    .exm_wen  (exm_wen),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .mwb_wen  (mwb_wen),
    .mwb_rd   (mwb_rd),
    .mwb_data (mwb_data),
    .data     (fwd1)
  );

  fwd_select #(.XW(XLEN), .AW(REG_AW)) u_fwd_rs2 (
    .addr     (src2_addr),
    .rf_data  (src2_rf),
    .exm_wen  (exm_wen),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .mwb_wen  (mwb_wen),
    .mwb_rd   (mwb_rd),
    .mwb_data (mwb_data),
    .data     (fwd2)
  );

  assign unused_fwd2_hi = ^fwd2[XLEN-1:5];
  assign dec            = decode_shift(in_is_shift, in_is_imm, in_funct3, in_imm);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_shamt   <= '0;
      out_alusel  <= NOP;
      out_rd_addr <= '0;
      out_illegal <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      is_imm_q    <= 1'b0;
    end else if (stall) begin
      if (out_valid) begin
        out_a <= fwd1;
        if (!is_imm_q) out_shamt <= fwd2[4:0];
      end
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a       <= fwd1;
        out_shamt   <= in_is_imm ? in_imm[4:0] : fwd2[4:0];
        out_alusel  <= dec.alusel;
        out_rd_addr <= in_rd_addr;
        out_illegal <= dec.illegal;
        rs1_q       <= in_rs1_addr;
        rs2_q       <= in_rs2_addr;
        is_imm_q    <= in_is_imm;
      end else begin
        out_alusel <= NOP;
      end
    end
  end

endmodule
